spi_slave_engine: RTL and testbench

SPI responder (slave) for the far end of the SPI master's link: samples `MOSI` and drives `MISO` from externally supplied `SCLK`/`CSn`, oversampled in the local `clk` domain. Supports all four CPOL/CPHA modes and both bit orders, with one-word transmit buffering and back-to-back words within one `CSn` assertion. It sits between the SPI pins and the local register/FIFO logic.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_slave_engine.sv | 143 ++++++++++++++
 tb/tb_spi_slave_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI responder: FSM states, mode-bit
// encodings and the CPOL/CPHA to edge-polarity mapping.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic CPHA_LEAD_SAMPLE = 1'b0;
  localparam logic ORDER_LSB_FIRST  = 1'b1;

  typedef struct packed {
    logic sample_rise;
    logic shift_rise;
  } edge_pol_t;

  // Leading edge leaves the CPOL level: CPOL=0 leads on rise, CPOL=1 on fall.
  function automatic edge_pol_t edge_pol(input logic cpol, input logic cpha);
    edge_pol_t p;
    p.sample_rise = ~(cpol ^ cpha);
    p.shift_rise  = cpol ^ cpha;
    return p;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with single-cycle rise/fall
// pulses derived from the synchronized value.
module spi_sync_edge #(
  parameter int   Stages = 2,
  parameter logic RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {Stages{RstVal}};
      prev_q <= RstVal;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign rise_o = sync_q[Stages-1] & ~prev_q;
  assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_slave_engine.sv
// SPI responder: oversamples SCLK/CSn/MOSI in the clk domain, assembles
// received words and shifts out a one-word-buffered transmit word on MISO.
module spi_slave_engine
  import spi_pkg::*;
#(
  parameter int WordLen    = 8,
  parameter int SyncStages = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SCLK,
  input  logic               CSn,
  input  logic               MOSI,
  output logic               MISO,
  output logic               MISO_OE,
  input  logic               CPOL,
  input  logic               CPHA,
  input  logic               BitOrder,
  input  logic [WordLen-1:0] TxData,
  input  logic               TxLoad,
  output logic               TxReady,
  output logic [WordLen-1:0] RxData,
  output logic               RxValid,
  output logic               Underrun,
  output logic               Busy
);

  localparam int              CntW    = $clog2(WordLen);
  localparam logic [CntW-1:0] LastBit = CntW'(WordLen - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_sync_edge #(.Stages(SyncStages), .RstVal(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d_i(SCLK), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.Stages(SyncStages), .RstVal(1'b1)) u_csn_sync (
    .clk(clk), .rst_n(rst_n), .d_i(CSn), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  state_e               state_q;
  logic [SyncStages-1:0] mosi_q;
  logic                 cpol_q, cpha_q, order_q;
  logic [CntW-1:0]      cnt_q;
  logic [WordLen-1:0]   rx_shift_q, tx_shift_q, tx_buf_q, rx_data_q;
  logic                 tx_full_q, rx_done_q, miso_q, rx_valid_q, underrun_q;

  edge_pol_t          pol;
  logic               active, select, deselect, sample_ev, shift_ev, load_pt;
  logic               mosi_s, out_bit, lsb_first;
  logic [WordLen-1:0] rx_next, tx_next, tx_buf_d;
  logic               tx_full_d;

  assign pol       = edge_pol(cpol_q, cpha_q);
  assign active    = (state_q == ACTIVE);
  assign select    = !active && cs_fall;
  assign deselect  = active && cs_rise;
  assign sample_ev = active && !cs_rise && (pol.sample_rise ? sclk_rise : sclk_fall);
  assign shift_ev  = active && !cs_rise && (pol.shift_rise ? sclk_rise : sclk_fall);
  // Word boundaries: select (CPHA=0 only) and any shift edge with the counter wrapped.
  assign load_pt   = (select && (CPHA == CPHA_LEAD_SAMPLE)) || (shift_ev && (cnt_q == '0));

  assign mosi_s    = mosi_q[SyncStages-1];
  assign lsb_first = (order_q == ORDER_LSB_FIRST);
  assign rx_next   = lsb_first ? {mosi_s, rx_shift_q[WordLen-1:1]}
                               : {rx_shift_q[WordLen-2:0], mosi_s};
  assign tx_next   = lsb_first ? {1'b0, tx_shift_q[WordLen-1:1]}
                               : {tx_shift_q[WordLen-2:0], 1'b0};
  assign out_bit   = lsb_first ? tx_shift_q[0] : tx_shift_q[WordLen-1];

  // A load point frees the buffer in the same cycle, so a coincident TxLoad lands.
  always_comb begin
    tx_full_d = tx_full_q;
    tx_buf_d  = tx_buf_q;
    if (load_pt) tx_full_d = 1'b0;
    if (TxLoad && (!tx_full_q || load_pt)) begin
      tx_full_d = 1'b1;
      tx_buf_d  = TxData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mosi_q     <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      order_q    <= 1'b0;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      mosi_q     <= {mosi_q[SyncStages-2:0], MOSI};
      tx_full_q  <= tx_full_d;
      tx_buf_q   <= tx_buf_d;
      rx_done_q  <= 1'b0;
      underrun_q <= 1'b0;
      rx_valid_q <= rx_done_q;
      if (rx_done_q) rx_data_q <= rx_shift_q;
      miso_q     <= active ? out_bit : 1'b0;

      if (select) begin
        state_q <= ACTIVE;
        cpol_q  <= CPOL;
        cpha_q  <= CPHA;
        order_q <= BitOrder;
        cnt_q   <= '0;
      end else if (deselect) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        tx_shift_q <= '0;
      end else begin
        if (sample_ev) begin
          rx_shift_q <= rx_next;
          cnt_q      <= (cnt_q == LastBit) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LastBit) rx_done_q <= 1'b1;
        end
        if (shift_ev && !load_pt) tx_shift_q <= tx_next;
      end

      if (load_pt) begin
        tx_shift_q <= tx_full_q ? tx_buf_q : '0;
        underrun_q <= !tx_full_q;
      end
    end
  end

  assign MISO     = miso_q & active;
  assign MISO_OE  = active;
  assign Busy     = active;
  assign TxReady  = !tx_full_q;
  assign RxData   = rx_data_q;
  assign RxValid  = rx_valid_q;
  assign Underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_engine.sv
// Bench for spi_slave_engine: an SPI master model drives the pins while a
// buffer/word reference model predicts received words, MISO words and underruns.
module tb_spi_slave_engine;

  localparam int W  = 8;
  localparam int NS = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         SCLK = 1'b0, CSn = 1'b1, MOSI = 1'b0;
  logic         CPOL = 1'b0, CPHA = 1'b0, BitOrder = 1'b0, TxLoad = 1'b0;
  logic [W-1:0] TxData = '0;
  logic         MISO, MISO_OE, TxReady, RxValid, Underrun, Busy;
  logic [W-1:0] RxData;

  spi_slave_engine #(.WordLen(W), .SyncStages(NS)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .CSn(CSn), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .CPOL(CPOL), .CPHA(CPHA), .BitOrder(BitOrder),
    .TxData(TxData), .TxLoad(TxLoad), .TxReady(TxReady), .RxData(RxData),
    .RxValid(RxValid), .Underrun(Underrun), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mid_q[$];
  logic [W-1:0] m_words[$];
  bit           buf_full = 1'b0;
  logic [W-1:0] buf_val = '0;
  logic [W-1:0] cur_tx = '0;
  logic [W-1:0] mon_exp;
  int           und_cnt = 0;
  int           exp_und = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference buffer model: a write lands only when the buffer is empty.
  task automatic tx_load(input logic [W-1:0] v);
    TxData = v;
    TxLoad = 1'b1;
    @(negedge clk);
    TxLoad = 1'b0;
    if (!buf_full) begin
      buf_full = 1'b1;
      buf_val  = v;
    end
  endtask

  task automatic model_load();
    cur_tx = buf_full ? buf_val : '0;
    if (!buf_full) exp_und++;
    buf_full = 1'b0;
  endtask

  // Monitor: every RxValid pulse pops one expected word.
  always @(negedge clk) begin
    if (rst_n && RxValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected got %0h required no word", RxData);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rx_data", 32'(RxData), 32'(mon_exp));
      end
    end
    if (rst_n && Underrun) und_cnt++;
  end

  // Sends nwords words from m_words; the last one carries last_bits bits.
  task automatic xfer(input logic cpol, input logic cpha, input logic order,
                      input int nwords, input int last_bits, input bit do_mid);
    int           hp, bits, idx;
    logic [W-1:0] word, got, exp_tx;
    hp = $urandom_range(5, 8);
    exp_tx = '0;
    CPOL = cpol; CPHA = cpha; BitOrder = order; SCLK = cpol;
    wait_clk(6);
    CSn = 1'b0;
    if (!cpha) model_load();
    wait_clk(8);
    chk("busy_active", 32'(Busy), 32'd1);
    chk("miso_oe_active", 32'(MISO_OE), 32'd1);
    for (int w = 0; w < nwords; w++) begin
      word = m_words.pop_front();
      bits = (w == nwords - 1) ? last_bits : W;
      got  = '0;
      if (bits == W) exp_q.push_back(word);
      if (!cpha) exp_tx = cur_tx;
      for (int b = 0; b < bits; b++) begin
        idx = order ? b : W - 1 - b;
        if (do_mid && b == 4 && mid_q.size() > 0) tx_load(mid_q.pop_front());
        if (!cpha) begin
          MOSI = word[idx];
          wait_clk(hp);
          got[idx] = MISO;
          SCLK = ~cpol;
          wait_clk(hp);
          SCLK = cpol;
          if (b == W - 1) model_load();
        end else begin
          SCLK = ~cpol;
          if (b == 0) begin
            model_load();
            exp_tx = cur_tx;
          end
          MOSI = word[idx];
          wait_clk(hp);
          got[idx] = MISO;
          SCLK = cpol;
          wait_clk(hp);
        end
      end
      if (bits == W) chk("miso_word", 32'(got), 32'(exp_tx));
    end
    wait_clk(hp);
    CSn = 1'b1;
    wait_clk(8);
    chk("miso_oe_idle", 32'(MISO_OE), 32'd0);
    chk("miso_idle", 32'(MISO), 32'd0);
    chk("busy_idle", 32'(Busy), 32'd0);
    chk("tx_ready", 32'(TxReady), 32'(!buf_full));
    chk("underrun_cnt", 32'(und_cnt), 32'(exp_und));
    chk("rx_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miso"}, 32'(MISO), 32'd0);
    chk({tag, "_miso_oe"}, 32'(MISO_OE), 32'd0);
    chk({tag, "_tx_ready"}, 32'(TxReady), 32'd1);
    chk({tag, "_rx_data"}, 32'(RxData), 32'd0);
    chk({tag, "_rx_valid"}, 32'(RxValid), 32'd0);
    chk({tag, "_underrun"}, 32'(Underrun), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int nw, lb;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    check_reset_outputs("reset");

    // Mode 0, MSB first, 0xA5 out, 0x3C in
    tx_load(8'hA5);
    m_words.push_back(8'h3C);
    xfer(1'b0, 1'b0, 1'b0, 1, W, 1'b0);

    // Mode 3, LSB first, back-to-back with a mid-word reload
    tx_load(8'h81);
    mid_q.push_back(8'h7E);
    m_words.push_back(8'h12);
    m_words.push_back(8'h34);
    xfer(1'b1, 1'b1, 1'b1, 2, W, 1'b1);
    mid_q.delete();

    // Mode 1 with an empty buffer: zeros out, underrun every word
    m_words.push_back(8'($urandom));
    m_words.push_back(8'($urandom));
    xfer(1'b0, 1'b1, 1'b0, 2, W, 1'b0);

    // Mode 2 deselect after 5 bits, then a clean word
    tx_load(8'($urandom));
    m_words.push_back(8'($urandom));
    xfer(1'b1, 1'b0, 1'b0, 1, 5, 1'b0);
    m_words.push_back(8'($urandom));
    xfer(1'b1, 1'b0, 1'b0, 1, W, 1'b0);

    // Write while full is dropped
    tx_load(8'h55);
    chk("tx_ready_full", 32'(TxReady), 32'd0);
    tx_load(8'hFF);
    chk("tx_ready_still_full", 32'(TxReady), 32'd0);
    m_words.push_back(8'($urandom));
    xfer(1'b0, 1'b0, 1'b0, 1, W, 1'b0);

    // Reset in the middle of a word
    tx_load(8'h99);
    CPOL = 1'b0; CPHA = 1'b0; BitOrder = 1'b0; SCLK = 1'b0;
    wait_clk(6);
    CSn = 1'b0;
    model_load();
    wait_clk(8);
    repeat (3) begin
      MOSI = 1'($urandom_range(0, 1));
      wait_clk(6);
      SCLK = 1'b1;
      wait_clk(6);
      SCLK = 1'b0;
    end
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    buf_full = 1'b0;
    exp_q.delete();
    CSn = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    tx_load(8'hC3);
    m_words.push_back(8'h5A);
    xfer(1'b0, 1'b0, 1'b1, 1, W, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 8; t++) begin
      nw = $urandom_range(1, 3);
      lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : W;
      if ($urandom_range(0, 1) == 1) tx_load(8'($urandom));
      for (int k = 0; k < nw; k++) begin
        m_words.push_back(8'($urandom));
        mid_q.push_back(8'($urandom));
      end
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           nw, lb, 1'($urandom_range(0, 1)));
      mid_q.delete();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
